// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: class encodings, sizing defaults, opcode decode.
package tomasulo_pkg;

  localparam int unsigned ROB_DEPTH_DEF = 8;
  localparam int unsigned ROB_AW_DEF    = 3;
  localparam int unsigned RS_DEPTH_DEF  = 3;
  localparam int unsigned FUNC_W        = 4;
  localparam int unsigned REG_W         = 4;
  localparam int unsigned N_CLS         = 3;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_BCH = 2'd2,
    CLS_ILL = 2'd3
  } op_class_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
  } alloc_rec_t;

  // Opcode class comes from func[3:1]; everything outside add/mul/branch is illegal.
  function automatic op_class_e decode_class(input logic [FUNC_W-1:0] func);
    case (func[3:1])
      3'b000:  return CLS_ADD;
      3'b001:  return CLS_MUL;
      3'b010:  return CLS_BCH;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/rs_occ_counter.sv
// Occupancy counter for one reservation-station class; saturating at both ends.
module rs_occ_counter #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = 2
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full_c,
  output logic          underflow_c
);

  logic inc_ok_c;
  logic dec_ok_c;

  // Bounds checks; a release of an empty class is dropped and flagged.
  always_comb begin
    full_c      = (cnt >= CW'(DEPTH));
    inc_ok_c    = inc & ~full_c;
    dec_ok_c    = dec & (cnt != '0);
    underflow_c = dec & (cnt == '0);
  end

  // Count update; simultaneous inc and dec cancel.
  always_ff @(posedge clk1) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(inc_ok_c) - CW'(dec_ok_c);
    end
  end

endmodule

// File: rtl/issue_alloc_ctrl.sv
// Issue-stage allocation: gates the decode-queue head on ROB/RS space and emits the allocation record.
module issue_alloc_ctrl
  import tomasulo_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int unsigned ROB_AW    = ROB_AW_DEF,
  parameter int unsigned RS_DEPTH  = RS_DEPTH_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  output logic              alloc_valid,
  output logic [ROB_AW-1:0] alloc_rob,
  output logic [1:0]        alloc_class,
  output logic [3:0]        alloc_func,
  output logic [3:0]        alloc_rd,
  output logic [3:0]        alloc_rs1,
  output logic [3:0]        alloc_rs2,
  input  logic [2:0]        rs_free,
  input  logic              commit,
  input  logic              flush,
  output logic [ROB_AW-1:0] head_p,
  output logic [ROB_AW-1:0] tail_p,
  output logic [ROB_AW:0]   rob_count,
  output logic [15:0]       stall_cnt,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  op_class_e        cls_c;
  logic             legal_c;
  logic             run_c;
  logic             rob_full_c;
  logic             cls_full_c;
  logic             accept_c;
  logic             acc_legal_c;
  logic             ev_en_c;
  logic             commit_ok_c;
  logic             commit_err_c;
  logic             err_c;
  logic [N_CLS-1:0] cls_inc_c;
  logic [N_CLS-1:0] cls_dec_c;
  logic [N_CLS-1:0] cls_full_vec_c;
  logic [N_CLS-1:0] free_err_c;
  logic [CNT_W-1:0] cls_cnt [N_CLS];
  alloc_rec_t       rec_c;
  alloc_rec_t       rec_q;

  // Decode, handshake and event qualification; flush masks every other event.
  always_comb begin
    cls_c      = decode_class(in_func);
    legal_c    = (cls_c != CLS_ILL);
    run_c      = (state_q == ST_RUN);
    rob_full_c = (rob_count >= (ROB_AW+1)'(ROB_DEPTH));
    cls_full_c = 1'b0;
    case (cls_c)
      CLS_ADD: cls_full_c = cls_full_vec_c[0];
      CLS_MUL: cls_full_c = cls_full_vec_c[1];
      CLS_BCH: cls_full_c = cls_full_vec_c[2];
      default: cls_full_c = 1'b0;
    endcase
    in_ready     = run_c & (~legal_c | (~rob_full_c & ~cls_full_c));
    accept_c     = in_valid & in_ready & ~flush;
    acc_legal_c  = accept_c & legal_c;
    ev_en_c      = run_c & ~flush;
    commit_ok_c  = ev_en_c & commit & (rob_count != '0);
    commit_err_c = ev_en_c & commit & (rob_count == '0);
    cls_inc_c[0] = acc_legal_c & (cls_c == CLS_ADD);
    cls_inc_c[1] = acc_legal_c & (cls_c == CLS_MUL);
    cls_inc_c[2] = acc_legal_c & (cls_c == CLS_BCH);
    cls_dec_c    = rs_free & {N_CLS{ev_en_c}};
    err_c        = (accept_c & ~legal_c) | commit_err_c | (|free_err_c);
    rec_c        = '{func: in_func, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
  end

  // Per-class RS occupancy.
  for (genvar c = 0; c < N_CLS; c++) begin : g_cls
    rs_occ_counter #(
      .DEPTH (RS_DEPTH),
      .CW    (CNT_W)
    ) u_cnt (
      .clk1        (clk1),
      .rst         (rst),
      .clr         (flush),
      .inc         (cls_inc_c[c]),
      .dec         (cls_dec_c[c]),
      .cnt         (cls_cnt[c]),
      .full_c      (cls_full_vec_c[c]),
      .underflow_c (free_err_c[c])
    );
  end

  // FSM next state: a flush costs exactly one dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk1) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // ROB pointers, occupancy, allocation record and error pulse.
  always_ff @(posedge clk1) begin
    if (rst) begin
      head_p      <= '0;
      tail_p      <= '0;
      rob_count   <= '0;
      alloc_valid <= 1'b0;
      alloc_rob   <= '0;
      alloc_class <= '0;
      rec_q       <= '0;
      err         <= 1'b0;
    end else begin
      alloc_valid <= acc_legal_c;
      err         <= err_c;
      if (acc_legal_c) begin
        alloc_rob   <= tail_p;
        alloc_class <= cls_c;
        rec_q       <= rec_c;
      end
      if (flush) begin
        tail_p    <= head_p;
        rob_count <= '0;
      end else begin
        head_p    <= head_p + ROB_AW'(commit_ok_c);
        tail_p    <= tail_p + ROB_AW'(acc_legal_c);
        rob_count <= rob_count + (ROB_AW+1)'(acc_legal_c) - (ROB_AW+1)'(commit_ok_c);
      end
    end
  end

  // Saturating count of cycles the queue head waits.
  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign alloc_func = rec_q.func;
  assign alloc_rd   = rec_q.rd;
  assign alloc_rs1  = rec_q.rs1;
  assign alloc_rs2  = rec_q.rs2;

endmodule

// File: tb/tb_issue_alloc_ctrl.sv
// Directed bench for issue_alloc_ctrl with hand-computed expectations.
module tb_issue_alloc_ctrl;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_BCH = 4'b0100;
  localparam logic [3:0] F_ILL = 4'b1111;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func, in_rd, in_rs1, in_rs2;
  logic        alloc_valid;
  logic [2:0]  alloc_rob;
  logic [1:0]  alloc_class;
  logic [3:0]  alloc_func, alloc_rd, alloc_rs1, alloc_rs2;
  logic [2:0]  rs_free;
  logic        commit;
  logic        flush;
  logic [2:0]  head_p, tail_p;
  logic [3:0]  rob_count;
  logic [15:0] stall_cnt;
  logic        err;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk1 = ~clk1;

  issue_alloc_ctrl dut (
    .clk1(clk1), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alloc_valid(alloc_valid), .alloc_rob(alloc_rob), .alloc_class(alloc_class),
    .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rs1(alloc_rs1), .alloc_rs2(alloc_rs2),
    .rs_free(rs_free), .commit(commit), .flush(flush),
    .head_p(head_p), .tail_p(tail_p), .rob_count(rob_count),
    .stall_cnt(stall_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] rd);
    in_valid = v;
    in_func  = f;
    in_rd    = rd;
    in_rs1   = 4'(rd + 4'd1);
    in_rs2   = 4'(rd + 4'd2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, F_ADD, 4'd0);
    rs_free = 3'b000;
    commit  = 1'b0;
    flush   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] fn_of(input int c);
    return 4'(c * 2);
  endfunction

  initial begin
    do_reset();
    // Reset state
    chk("rst_valid", 32'(alloc_valid), 32'd0);
    chk("rst_head",  32'(head_p), 32'd0);
    chk("rst_tail",  32'(tail_p), 32'd0);
    chk("rst_count", 32'(rob_count), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // 1: three adds back to back, then the fourth add stalls at the head
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, F_ADD, 4'(k + 1));
      tick();
      chk("t1_valid", 32'(alloc_valid), 32'd1);
      chk("t1_rob",   32'(alloc_rob), 32'(k));
      chk("t1_rd",    32'(alloc_rd), 32'(k + 1));
    end
    chk("t1_rs1",   32'(alloc_rs1), 32'd4);
    chk("t1_rs2",   32'(alloc_rs2), 32'd5);
    chk("t1_class", 32'(alloc_class), 32'd0);
    chk("t1_count", 32'(rob_count), 32'd3);
    drive(1'b1, F_ADD, 4'd4);
    #1;
    chk("t1_add_full", 32'(in_ready), 32'd0);
    in_func = F_MUL;
    #1;
    chk("t1_mul_room", 32'(in_ready), 32'd1);
    in_func = F_ADD;
    tick();
    chk("t1_noalloc", 32'(alloc_valid), 32'd0);
    chk("t1_stall1",  32'(stall_cnt), 32'd1);
    tick();
    chk("t1_stall2",  32'(stall_cnt), 32'd2);
    chk("t1_tail",    32'(tail_p), 32'd3);

    // 2: fill the ROB with mixed ops, releasing each RS slot one cycle later
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, fn_of(k % 3), 4'(k));
      rs_free = (k == 0) ? 3'b000 : 3'(1 << ((k - 1) % 3));
      tick();
      chk("t2_valid", 32'(alloc_valid), 32'd1);
      chk("t2_rob",   32'(alloc_rob), 32'(k));
    end
    rs_free = 3'b000;
    chk("t2_class", 32'(alloc_class), 32'd1);
    chk("t2_count", 32'(rob_count), 32'd8);
    chk("t2_tail",  32'(tail_p), 32'd0);
    chk("t2_err",   32'(err), 32'd0);
    drive(1'b1, F_ADD, 4'd9);
    commit = 1'b1;
    #1;
    chk("t2_full", 32'(in_ready), 32'd0);
    tick();
    commit = 1'b0;
    chk("t2_head",    32'(head_p), 32'd1);
    chk("t2_cnt7",    32'(rob_count), 32'd7);
    chk("t2_stall",   32'(stall_cnt), 32'd1);
    chk("t2_noalloc", 32'(alloc_valid), 32'd0);
    tick();
    chk("t2_wvalid", 32'(alloc_valid), 32'd1);
    chk("t2_wrob",   32'(alloc_rob), 32'd0);
    chk("t2_wtail",  32'(tail_p), 32'd1);
    chk("t2_wcount", 32'(rob_count), 32'd8);

    // 3: accept and commit in the same cycle at rob_count=4
    do_reset();
    drive(1'b1, F_ADD, 4'd1); tick();
    drive(1'b1, F_MUL, 4'd2); tick();
    drive(1'b1, F_BCH, 4'd3); tick();
    drive(1'b1, F_ADD, 4'd4); tick();
    chk("t3_count4", 32'(rob_count), 32'd4);
    drive(1'b1, F_MUL, 4'd5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t3_count", 32'(rob_count), 32'd4);
    chk("t3_head",  32'(head_p), 32'd1);
    chk("t3_tail",  32'(tail_p), 32'd5);
    chk("t3_rob",   32'(alloc_rob), 32'd4);
    chk("t3_class", 32'(alloc_class), 32'd1);

    // 4: flush with five in flight
    drive(1'b1, F_BCH, 4'd6); tick();
    chk("t4_count5", 32'(rob_count), 32'd5);
    drive(1'b1, F_ADD, 4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_count", 32'(rob_count), 32'd0);
    chk("t4_tail",  32'(tail_p), 32'd1);
    chk("t4_head",  32'(head_p), 32'd1);
    chk("t4_valid", 32'(alloc_valid), 32'd0);
    chk("t4_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("t4_valid2", 32'(alloc_valid), 32'd0);
    chk("t4_stall",  32'(stall_cnt), 32'd1);
    chk("t4_ready1", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_arob", 32'(alloc_rob), 32'(k + 1));
    end
    chk("t4_addfull", 32'(in_ready), 32'd0);

    // 5: illegal opcode, free of an empty class, commit on empty ROB
    do_reset();
    drive(1'b1, F_ILL, 4'd3);
    #1;
    chk("t5_ill_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t5_ill_valid", 32'(alloc_valid), 32'd0);
    chk("t5_ill_err",   32'(err), 32'd1);
    chk("t5_ill_tail",  32'(tail_p), 32'd0);
    drive(1'b0, F_ADD, 4'd0);
    tick();
    chk("t5_err_clr", 32'(err), 32'd0);
    rs_free = 3'b001;
    tick();
    rs_free = 3'b000;
    chk("t5_free_err", 32'(err), 32'd1);
    drive(1'b1, F_ADD, 4'd0);
    #1;
    chk("t5_cnt_zero", 32'(in_ready), 32'd1);
    drive(1'b0, F_ADD, 4'd0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t5_cmt_err",  32'(err), 32'd1);
    chk("t5_cmt_head", 32'(head_p), 32'd0);

    // 6: reset while an allocation is being presented
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, F_ADD, 4'(k)); tick();
    end
    drive(1'b1, F_MUL, 4'd9); tick();
    chk("t6_pre_valid", 32'(alloc_valid), 32'd1);
    chk("t6_pre_stall", 32'(stall_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(alloc_valid), 32'd0);
    chk("t6_rob",   32'(alloc_rob), 32'd0);
    chk("t6_rd",    32'(alloc_rd), 32'd0);
    chk("t6_count", 32'(rob_count), 32'd0);
    chk("t6_tail",  32'(tail_p), 32'd0);
    chk("t6_stall", 32'(stall_cnt), 32'd0);
    chk("t6_err",   32'(err), 32'd0);
    drive(1'b0, F_ADD, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
